// File: rtl/serial_tx_buf_if.sv
// serial_tx_buf_if: fabric-side bundle of the buffered UART transmitter.
//   i_wr        write strobe, byte on i_data sampled at the rising clock edge
//   i_data      byte to transmit
//   o_full      FIFO holds 2^N_ADDR bytes
//   o_busy      FIFO non-empty or a frame in progress
//   o_overflow  sticky flag, a write was dropped
//   o_tx        serial line, idle high
// master = fabric driving writes, slave = the transmitter.
interface serial_tx_buf_if;
  logic       i_wr;
  logic [7:0] i_data;
  logic       o_full;
  logic       o_busy;
  logic       o_overflow;
  logic       o_tx;

  modport master (
    output i_wr, i_data,
    input  o_full, o_busy, o_overflow, o_tx
  );

  modport slave (
    input  i_wr, i_data,
    output o_full, o_busy, o_overflow, o_tx
  );
endinterface

// File: rtl/serial_tx_buf.sv
// serial_tx_buf: FIFO-buffered UART transmitter, 8N1 frames LSB first
// (8E1 when SERIAL_TX_BUF_PARITY_EN is defined).
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset; forces the line idle-high at once
//   bus      serial_tx_buf_if.slave (i_wr, i_data, o_full, o_busy,
//            o_overflow, o_tx)
// Parameters: CLK_FREQ (Hz), BAUD_RATE (bit/s), N_ADDR (FIFO depth 2^N_ADDR).
// Optional feature macro: SERIAL_TX_BUF_PARITY_EN (even parity bit after D7).
module serial_tx_buf #(
  parameter int unsigned CLK_FREQ  = 48_000_000,
  parameter int unsigned BAUD_RATE = 115_200,
  parameter int unsigned N_ADDR    = 3
) (
  input logic            i_clk,
  input logic            i_rst_n,
  serial_tx_buf_if.slave bus
);

  localparam int unsigned DIV   = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DEPTH = 1 << N_ADDR;
  localparam int unsigned CW    = N_ADDR + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef SERIAL_TX_BUF_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic [N_ADDR-1:0]  rd_ptr_q, rd_ptr_d;
  logic [N_ADDR-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               overflow_q, overflow_d;
`ifdef SERIAL_TX_BUF_PARITY_EN
  logic               par_q, par_d;
`endif
  logic [7:0]         mem_q [DEPTH];

  logic               baud_last;
  logic               pop;
  logic               push;
  logic               full_c;

  assign baud_last = (baud_q == CNT_W'(DIV - 1));
  assign full_c    = (count_q == CW'(DEPTH));

  // Next-state: frame sequencing, FIFO pointers/count and registered outputs
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    pop        = 1'b0;
    push       = 1'b0;
    tx_d       = 1'b1;
`ifdef SERIAL_TX_BUF_PARITY_EN
    par_d      = par_q;
`endif

    if (state_q != S_IDLE) begin
      baud_d = baud_last ? '0 : baud_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) pop = 1'b1;
      end
      S_START: begin
        if (baud_last) state_d = S_DATA;
      end
      S_DATA: begin
        if (baud_last) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef SERIAL_TX_BUF_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef SERIAL_TX_BUF_PARITY_EN
      S_PARITY: begin
        if (baud_last) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // Chain straight into the next start bit when more bytes wait
        if (baud_last) begin
          if (count_q != '0) pop = 1'b1;
          else               state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      state_d  = S_START;
      baud_d   = '0;
      bit_d    = '0;
      shift_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + N_ADDR'(1);
`ifdef SERIAL_TX_BUF_PARITY_EN
      par_d    = ^mem_q[rd_ptr_q];
`endif
    end

    // A full FIFO still accepts when its head leaves on the same edge
    push = bus.i_wr && (!full_c || pop);
    if (push) wr_ptr_d = wr_ptr_q + N_ADDR'(1);
    if (bus.i_wr && !push) overflow_d = 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Line level follows the state being entered so o_tx is a clean flop
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef SERIAL_TX_BUF_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  // Control and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef SERIAL_TX_BUF_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
`ifdef SERIAL_TX_BUF_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.i_data;
  end

  assign bus.o_tx       = tx_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_overflow = overflow_q;
  assign bus.o_full     = full_c;

endmodule

// File: tb/tb_serial_tx_buf.sv
// tb_serial_tx_buf: directed and randomized checks of serial_tx_buf against a
// queue-based model of the transmitter (frame timing derived from bit periods).
module tb_serial_tx_buf;

  localparam int unsigned CLK_FREQ  = 1_000_000;
  localparam int unsigned BAUD_RATE = 77_000;
  localparam int unsigned N_ADDR    = 3;
  localparam int DIV   = CLK_FREQ / BAUD_RATE;
  localparam int DEPTH = 1 << N_ADDR;
`ifdef SERIAL_TX_BUF_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  serial_tx_buf_if bus ();

  serial_tx_buf #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE),
    .N_ADDR   (N_ADDR)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model: pending bytes, byte on the line and position in its frame
  logic [7:0] m_q[$];
  logic [7:0] m_cur;
  int         m_pos;
  bit         m_active;
  bit         m_ovf;

  function automatic void model_reset();
    m_q.delete();
    m_cur    = '0;
    m_pos    = 0;
    m_active = 0;
    m_ovf    = 0;
  endfunction

  function automatic void model_step(input logic wr, input logic [7:0] d);
    bit pop;
    bit accept;
    pop = 0;
    if (!m_active || m_pos == FRAME - 1) pop = (m_q.size() > 0);
    accept = wr && ((m_q.size() < DEPTH) || pop);
    if (m_active) begin
      if (m_pos == FRAME - 1) m_active = 0;
      else                    m_pos++;
    end
    if (pop) begin
      m_cur    = m_q.pop_front();
      m_active = 1;
      m_pos    = 0;
    end
    if (accept)  m_q.push_back(d);
    else if (wr) m_ovf = 1;
  endfunction

  function automatic logic exp_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / DIV;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
`ifdef SERIAL_TX_BUF_PARITY_EN
    if (b == 9) return ^m_cur;
`endif
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("tx",       32'(bus.o_tx),       32'(exp_tx()));
    chk("busy",     32'(bus.o_busy),     32'(m_active || (m_q.size() > 0)));
    chk("full",     32'(bus.o_full),     32'(m_q.size() == DEPTH));
    chk("overflow", 32'(bus.o_overflow), 32'(m_ovf));
  endtask

  // One clock: drive, let the DUT sample, advance the model, compare mid-cycle
  task automatic step(input logic wr, input logic [7:0] d);
    bus.i_wr   = wr;
    bus.i_data = d;
    @(posedge clk);
    model_step(wr, d);
    @(negedge clk);
    bus.i_wr = 1'b0;
    check_all();
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((m_active || m_q.size() > 0) && n < limit) begin
      step(1'b0, 8'h00);
      n++;
    end
    if (m_active || m_q.size() > 0) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout observed=%0d cycles expected=idle", n);
    end
    step(1'b0, 8'h00);
  endtask

  // Send one byte from idle and sample the bit after D7 mid-period
  task automatic probe_bit9(input logic [7:0] d, input logic exp_b9, input string tag);
    step(1'b1, d);
    for (int i = 0; i < FRAME + 4; i++) begin
      step(1'b0, 8'h00);
      if (m_active && m_pos == 9 * DIV + DIV / 2) chk(tag, 32'(bus.o_tx), 32'(exp_b9));
    end
  endtask

  initial begin
    int n;
    bus.i_wr   = 1'b0;
    bus.i_data = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_tx",   32'(bus.o_tx),       32'd1);
    chk("rst_busy", 32'(bus.o_busy),     32'd0);
    chk("rst_full", 32'(bus.o_full),     32'd0);
    chk("rst_ovf",  32'(bus.o_overflow), 32'd0);
    rst_n = 1'b1;
    step(1'b0, 8'h00);

    // Single 0x55: busy rises after the write, falls FRAME+1 cycles later
    step(1'b1, 8'h55);
    chk("single_busy_rise", 32'(bus.o_busy), 32'd1);
    chk("single_tx_before_pop", 32'(bus.o_tx), 32'd1);
    n = 0;
    do begin
      step(1'b0, 8'h00);
      n++;
      if (n == 1) chk("single_start_low", 32'(bus.o_tx), 32'd0);
    end while (bus.o_busy === 1'b1 && n < FRAME + 20);
    chk("single_busy_len", 32'(n), 32'(FRAME + 1));

    // Burst of 8 back-to-back frames
    for (int i = 0; i < 8; i++) step(1'b1, 8'(i));
    drain(9 * FRAME);
    chk("burst_ovf", 32'(bus.o_overflow), 32'd0);

    // 10 writes from idle: 9 fit, the 10th is dropped
    for (int i = 0; i < 10; i++) step(1'b1, 8'h30 + 8'(i));
    chk("ten_full", 32'(bus.o_full),     32'd1);
    chk("ten_ovf",  32'(bus.o_overflow), 32'd1);

    // Write on the exact edge the full FIFO pops at the stop/start boundary
    n = 0;
    while (!(m_active && m_pos == FRAME - 2) && n < 2 * FRAME) begin
      step(1'b0, 8'h00);
      n++;
    end
    step(1'b0, 8'h00);
    chk("boundary_pre_full", 32'(bus.o_full), 32'd1);
    step(1'b1, 8'hC3);
    chk("boundary_full_kept", 32'(bus.o_full), 32'd1);
    chk("boundary_start_low", 32'(bus.o_tx),   32'd0);
    drain(10 * FRAME);
    chk("ovf_sticky", 32'(bus.o_overflow), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) step(1'b1, 8'($urandom));
      else                           step(1'b0, 8'h00);
    end
    for (int i = 0; i < 12; i++) step(1'b1, 8'($urandom));
    drain(10 * FRAME);

    // Reset in the middle of the data bits of 0x00
    step(1'b1, 8'h00);
    step(1'b1, 8'h11);
    for (int i = 0; i < 2 * DIV + 3; i++) step(1'b0, 8'h00);
    chk("pre_reset_tx_low", 32'(bus.o_tx), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_async_tx",   32'(bus.o_tx),       32'd1);
    chk("reset_async_busy", 32'(bus.o_busy),     32'd0);
    chk("reset_async_full", 32'(bus.o_full),     32'd0);
    chk("reset_async_ovf",  32'(bus.o_overflow), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'h00);
    step(1'b1, 8'hA5);
    drain(2 * FRAME);

    // Bit after D7: parity when compiled in, otherwise the stop bit
`ifdef SERIAL_TX_BUF_PARITY_EN
    probe_bit9(8'h07, 1'b1, "parity_07");
    probe_bit9(8'h03, 1'b0, "parity_03");
`else
    probe_bit9(8'h07, 1'b1, "stop_07");
    probe_bit9(8'h03, 1'b1, "stop_03");
`endif
    drain(2 * FRAME);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
